fb_page_streamer: RTL
=====================

# fb_page_streamer

Reader end of the monochrome framebuffer read port. On `start` it walks the 128x64 framebuffer in SSD1306 page order: page 0..7, column 0..127 within each page. For each byte it performs a column-mode read (`fb_r_mode=1`) and emits the result on a valid/ready byte stream toward the OLED SPI command/data driver. One full frame is 1024 bytes.

## Interface
Parameters:
- `H_PIXELS`, default 128: display width in pixels and columns per page.
- `V_PIXELS`, default 64: display height. Pages = `V_PIXELS/8`; must be a multiple of 8.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request to stream a full frame.
- `busy`, out, 1: high from accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last byte is accepted.
- `fb_rst_complete`, in, 1: framebuffer clear finished.
- `fb_busy`, in, 1: framebuffer internal operation in progress.
- `fb_re`, out, 1: read request to the framebuffer.
- `fb_r_xpos`, out, 8: read column.
- `fb_r_ypos`, out, 8: read row, always `page*8`.
- `fb_r_mode`, out, 1: constant 1 (column mode).
- `fb_r_data_valid`, in, 1: framebuffer read acknowledge.
- `fb_dout`, in, 8: framebuffer read data. MSB = top row of the column.
- `out_valid`, out, 1: stream byte valid.
- `out_ready`, in, 1: downstream accept.
- `out_data`, out, 8: stream byte.
- `out_first`, out, 1: qualifies the byte at page 0, column 0.
- `out_last`, out, 1: qualifies the byte at page 7, column 127.

## Operation
FSM states:
- **IDLE**: `start` loads col=0, page=0 and moves to WAIT_FB. `busy` rises on the next edge.
- **WAIT_FB**: wait for `fb_rst_complete && !fb_busy`, then go to REQ.
- **REQ**: drive `fb_re=1` with addresses stable. Stay until `fb_r_data_valid=1`, then go to CAPTURE.
- **CAPTURE**: `fb_re` stays 1. Latch `fb_dout` into the data register on this edge, one cycle after valid was first seen. Go to RELEASE.
- **RELEASE**: `fb_re=0`. Wait until `fb_r_data_valid=0`, then go to PUSH. This is a four-phase handshake; a new request is never issued while valid is still high.
- **PUSH**: hold `out_valid=1` with stable `out_data`, `out_first` and `out_last` until `out_ready`. On the accepting edge:
  - last byte: go to DONE;
  - otherwise col = col+1; when col reaches `H_PIXELS-1` it wraps to 0 and page increments. Go to REQ.
- **DONE**: `done=1` for one cycle, `busy` drops, go to IDLE.

Rules:
- `start` while `busy` is ignored.
- `fb_busy` is checked only in WAIT_FB, once per frame.
- Asynchronous `rst` in any state forces IDLE, clears the counters and drops `fb_re` immediately. The framebuffer handles an abandoned request by its own handshake rules.
- Counter widths: col is `$clog2(H_PIXELS)` bits, page is `$clog2(V_PIXELS/8)` bits.
- `fb_r_ypos = {page, 3'b000}`, zero-extended to 8 bits.

## Timing
- Reset values: `busy=0`, `done=0`, `fb_re=0`, `fb_r_xpos=0`, `fb_r_ypos=0`, `fb_r_mode=1`, `out_valid=0`, `out_data=0`, `out_first=0`, `out_last=0`.
- Outputs are all registered.
- Per-byte cost: framebuffer latency L + 1 (CAPTURE) + release wait R + 1 (PUSH with `out_ready` held high).
- Frame cost: 1024 × per-byte cost + WAIT_FB + 1.
- `out_data` changes only on entry to PUSH. `out_valid` never drops before acceptance.

## Configuration
- `FB_STREAMER_BITREV_EN` defined: `out_data[i] = captured[7-i]`. LSB is the top row, matching SSD1306 GDDRAM bit order.
- Not defined: `out_data = captured`, pass-through with MSB as the top row.

## Structure
- Shared package `fb_pkg`:
  - `H_PIXELS` / `V_PIXELS` defaults;
  - `FB_PAGES`;
  - `FB_RMODE_ROW=0`, `FB_RMODE_COL=1`;
  - the streamer state enum typedef.
- One sub-module, `fb_read_req`: the four-phase REQ/CAPTURE/RELEASE handshake, taking an address and returning a captured byte with a one-cycle `rd_done`. The top holds the counters, stream register and FSM.

## Test plan
- **Reset mid-frame:** assert `rst` during REQ at page 3 → `fb_re` falls with no clock edge; all outputs hold reset values; next `start` begins at (0,0) with `out_first=1`.
- **Column pattern:** framebuffer rows 0..7 at x=0..7 hold 0xCC,0xAA,0xF0,0x0F,0xCC,0xAA,0xF0,0x0F.
  - Without the macro, the first 8 bytes are 0xEE,0xAA,0x66,0x22,0xDD,0x99,0x55,0x11.
  - With `FB_STREAMER_BITREV_EN`, they are 0x77,0x55,0x66,0x44,0xBB,0x99,0xAA,0x88.
- **Full frame on cleared framebuffer, `out_ready` tied high:**
  - exactly 1024 bytes, all 0x00;
  - `out_first` only on byte 0 and `out_last` only on byte 1023;
  - `fb_r_ypos` sequence 0,8,…,56; `done` pulses once.
- **Backpressure:** `out_ready` low for 5 cycles at byte 130 → `out_valid` and `out_data` stay stable; no `fb_re` rises during the stall; byte 130 reads address (2,8).
- **Busy gating and start:**
  - `fb_rst_complete` low for 20 cycles after `start` → `fb_re` stays low until it rises, then the first request follows within 1 cycle.
  - A second `start` pulse mid-frame has no effect.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer page streamer.
//   FB_H_PIXELS / FB_V_PIXELS : default display geometry (128x64)
//   FB_PAGES                  : 8-row pages per frame
//   FB_RMODE_ROW / FB_RMODE_COL : framebuffer read-mode encodings
//   stream_state_t            : top-level streamer FSM states
//   rd_state_t                : four-phase read handshake states
//   bit_rev8                  : byte bit-reversal helper
package fb_pkg;

  localparam int FB_H_PIXELS = 128;
  localparam int FB_V_PIXELS = 64;
  localparam int FB_PAGES    = FB_V_PIXELS / 8;

  localparam logic FB_RMODE_ROW = 1'b0;
  localparam logic FB_RMODE_COL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FB,
    ST_READ,
    ST_PUSH,
    ST_DONE
  } stream_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_CAPTURE,
    RD_RELEASE
  } rd_state_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/fb_read_req.sv
// Four-phase framebuffer read: raise fb_re, wait for fb_r_data_valid, capture
// fb_dout one cycle later, drop fb_re, then wait for valid to fall before
// reporting completion. A new request is never started while valid is high.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   go              : start one read (sampled only in RD_IDLE)
//   fb_r_data_valid : framebuffer acknowledge
//   fb_dout         : framebuffer read data
//   fb_re           : registered read request
//   rd_data         : captured byte
//   rd_done         : one-cycle, high on the last RD_RELEASE cycle
//   state           : current handshake state (debug visibility)
module fb_read_req
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       fb_r_data_valid,
  input  logic [7:0] fb_dout,
  output logic       fb_re,
  output logic [7:0] rd_data,
  output logic       rd_done,
  output rd_state_t  state
);

  rd_state_t state_next;

  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE:    if (go) state_next = RD_REQ;
      RD_REQ:     if (fb_r_data_valid) state_next = RD_CAPTURE;
      RD_CAPTURE: state_next = RD_RELEASE;
      RD_RELEASE: if (!fb_r_data_valid) state_next = RD_IDLE;
      default:    state_next = RD_IDLE;
    endcase
  end

  // Completion is reported in the same cycle the release is observed so the
  // caller can load its output register on the edge that ends the read.
  assign rd_done = (state == RD_RELEASE) && !fb_r_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      fb_re   <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      state <= state_next;
      fb_re <= (state_next == RD_REQ) || (state_next == RD_CAPTURE);
      // Data is taken one cycle after valid was first seen.
      if (state == RD_CAPTURE) rd_data <= fb_dout;
    end
  end

endmodule

// File: rtl/fb_page_streamer.sv
// Streams a full monochrome framebuffer in SSD1306 page order (page 0..N-1,
// column 0..H-1 within each page) as column-mode reads, one byte per read.
// Optional build macro: FB_STREAMER_BITREV_EN -- when defined the captured
// byte is bit-reversed so the LSB carries the top row (GDDRAM order);
// otherwise the byte passes through with the MSB as the top row.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, busy, done   : frame request / in-progress / one-cycle completion
//   fb_rst_complete     : framebuffer clear finished
//   fb_busy             : framebuffer internal operation (checked once/frame)
//   fb_re, fb_r_xpos, fb_r_ypos, fb_r_mode : read request and address
//   fb_r_data_valid, fb_dout : read acknowledge and data
//   out_valid, out_ready, out_data, out_first, out_last : byte stream
// Stream handshake: a byte transfers on a rising edge where out_valid and
// out_ready are both high; once raised, out_valid and its payload stay
// stable until that edge.
module fb_page_streamer
  import fb_pkg::*;
#(
  parameter int H_PIXELS = FB_H_PIXELS,
  parameter int V_PIXELS = FB_V_PIXELS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       fb_rst_complete,
  input  logic       fb_busy,
  output logic       fb_re,
  output logic [7:0] fb_r_xpos,
  output logic [7:0] fb_r_ypos,
  output logic       fb_r_mode,
  input  logic       fb_r_data_valid,
  input  logic [7:0] fb_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_first,
  output logic       out_last
);

  localparam int PAGES  = V_PIXELS / 8;
  localparam int COL_W  = $clog2(H_PIXELS);
  localparam int PAGE_W = $clog2(PAGES);

  stream_state_t     state, state_next;
  logic [COL_W-1:0]  col;
  logic [PAGE_W-1:0] page;
  logic              rd_go;
  logic              rd_done;
  logic [7:0]        rd_data;
  logic [7:0]        shaped;
  logic              is_last;
  logic              col_wrap;
  rd_state_t         rd_state;

  fb_read_req u_read (
    .clk             (clk),
    .rst             (rst),
    .go              (rd_go),
    .fb_r_data_valid (fb_r_data_valid),
    .fb_dout         (fb_dout),
    .fb_re           (fb_re),
    .rd_data         (rd_data),
    .rd_done         (rd_done),
    .state           (rd_state)
  );

`ifdef FB_STREAMER_BITREV_EN
  assign shaped = bit_rev8(rd_data);
`else
  assign shaped = rd_data;
`endif

  assign col_wrap = (col == COL_W'(H_PIXELS - 1));
  assign is_last  = col_wrap && (page == PAGE_W'(PAGES - 1));

  // Addresses come straight from the counter flops, so they are stable for
  // the whole request.
  assign fb_r_xpos = 8'(col);
  assign fb_r_ypos = 8'({page, 3'b000});
  assign fb_r_mode = FB_RMODE_COL;

  always_comb begin
    state_next = state;
    rd_go      = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_next = ST_WAIT_FB;
      ST_WAIT_FB: begin
        if (fb_rst_complete && !fb_busy) begin
          state_next = ST_READ;
          rd_go      = 1'b1;
        end
      end
      ST_READ:    if (rd_done) state_next = ST_PUSH;
      ST_PUSH: begin
        if (out_ready) begin
          if (is_last) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_READ;
            rd_go      = 1'b1;
          end
        end
      end
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      col       <= '0;
      page      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != ST_IDLE);
      done      <= (state_next == ST_DONE);
      out_valid <= (state_next == ST_PUSH);

      if (state == ST_IDLE && start) begin
        col  <= '0;
        page <= '0;
      end

      // The payload is loaded only when entering PUSH, so it cannot change
      // while a byte is offered.
      if (state == ST_READ && rd_done) begin
        out_data  <= shaped;
        out_first <= (col == '0) && (page == '0);
        out_last  <= is_last;
      end

      if (state == ST_PUSH && out_ready && !is_last) begin
        if (col_wrap) begin
          col  <= '0;
          page <= page + PAGE_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule
